// File: rtl/mem_refill_arbiter_if.sv
// Miss-refill bundle: both cache miss ports plus the shared memory port.
interface mem_refill_arbiter_if #(
    parameter int ADDR_W = 59,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] icache_req_addr;
    logic              icache_req_addr_valid;
    logic              icache_ack_data_valid;
    logic [LINE_W-1:0] icache_ack_data;
    logic [ADDR_W-1:0] dcache_req_addr;
    logic              dcache_req_addr_valid;
    logic              dcache_ack_data_valid;
    logic [LINE_W-1:0] dcache_ack_data;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_valid;
    logic              mem_req_retry;
    logic              mem_ack_data_valid;
    logic [LINE_W-1:0] mem_ack_data;
    logic              arb_busy;
    logic              mem_timeout_err;

    modport master (
        output icache_req_addr, icache_req_addr_valid,
        input  icache_ack_data_valid, icache_ack_data,
        output dcache_req_addr, dcache_req_addr_valid,
        input  dcache_ack_data_valid, dcache_ack_data,
        input  mem_req_addr, mem_req_valid,
        output mem_req_retry, mem_ack_data_valid, mem_ack_data,
        input  arb_busy, mem_timeout_err
    );

    modport slave (
        input  icache_req_addr, icache_req_addr_valid,
        output icache_ack_data_valid, icache_ack_data,
        input  dcache_req_addr, dcache_req_addr_valid,
        output dcache_ack_data_valid, dcache_ack_data,
        output mem_req_addr, mem_req_valid,
        input  mem_req_retry, mem_ack_data_valid, mem_ack_data,
        output arb_busy, mem_timeout_err
    );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Round-robin icache/dcache line-refill arbiter, one memory request in flight,
// registered response steering and a sticky response watchdog.
module mem_refill_arbiter #(
    parameter int ADDR_W  = 59,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic clk,
    input  logic reset,
    mem_refill_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              gnt_dc_q, gnt_dc_d;
    logic              last_dc_q, last_dc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mreq_q, mreq_d;
    logic              iack_q, iack_d;
    logic              dack_q, dack_d;
    logic [LINE_W-1:0] idata_q, idata_d;
    logic [LINE_W-1:0] ddata_q, ddata_d;
    logic [TO_W-1:0]   wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              pick_dc;

    // dcache wins only when alone or when icache was served last
    assign pick_dc = bus.dcache_req_addr_valid &
                     (~bus.icache_req_addr_valid | ~last_dc_q);

    always_comb begin
        state_d   = state_q;
        gnt_dc_d  = gnt_dc_q;
        last_dc_d = last_dc_q;
        addr_d    = addr_q;
        mreq_d    = mreq_q;
        iack_d    = iack_q;
        dack_d    = dack_q;
        idata_d   = idata_q;
        ddata_d   = ddata_q;
        wdog_d    = wdog_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.icache_req_addr_valid || bus.dcache_req_addr_valid) begin
                    gnt_dc_d  = pick_dc;
                    last_dc_d = pick_dc;
                    addr_d    = pick_dc ? bus.dcache_req_addr : bus.icache_req_addr;
                    mreq_d    = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (!bus.mem_req_retry) begin
                    mreq_d  = 1'b0;
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ack_data_valid) begin
                    if (gnt_dc_q) begin
                        ddata_d = bus.mem_ack_data;
                        dack_d  = 1'b1;
                    end else begin
                        idata_d = bus.mem_ack_data;
                        iack_d  = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    if (wdog_q != '1) wdog_d = wdog_q + 1'b1;
                    if (TIMEOUT != 0 && wdog_q == TO_LAST) err_d = 1'b1;
                end
            end
            RESP: begin
                iack_d  = 1'b0;
                dack_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_dc_q  <= 1'b0;
            last_dc_q <= 1'b1;
            addr_q    <= '0;
            mreq_q    <= 1'b0;
            iack_q    <= 1'b0;
            dack_q    <= 1'b0;
            idata_q   <= '0;
            ddata_q   <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_dc_q  <= gnt_dc_d;
            last_dc_q <= last_dc_d;
            addr_q    <= addr_d;
            mreq_q    <= mreq_d;
            iack_q    <= iack_d;
            dack_q    <= dack_d;
            idata_q   <= idata_d;
            ddata_q   <= ddata_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
        end
    end

    assign bus.mem_req_addr          = addr_q;
    assign bus.mem_req_valid         = mreq_q;
    assign bus.icache_ack_data_valid = iack_q;
    assign bus.icache_ack_data       = idata_q;
    assign bus.dcache_ack_data_valid = dack_q;
    assign bus.dcache_ack_data       = ddata_q;
    assign bus.arb_busy              = (state_q != IDLE);
    assign bus.mem_timeout_err       = err_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter (watchdog TIMEOUT=8).
module tb_mem_refill_arbiter;

    localparam int AW = 59;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_refill_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_refill_arbiter #(
        .ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8), .TO_W(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.icache_req_addr       = '0;
        bus.icache_req_addr_valid = 1'b0;
        bus.dcache_req_addr       = '0;
        bus.dcache_req_addr_valid = 1'b0;
        bus.mem_req_retry         = 1'b0;
        bus.mem_ack_data_valid    = 1'b0;
        bus.mem_ack_data          = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        do_reset();
        n_chk++;
        if (bus.arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.arb_busy);
        end
        n_chk++;
        if (bus.mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mreq: got %b want 0", bus.mem_req_valid);
        end
        n_chk++;
        if (bus.mem_req_addr !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %h want 0", bus.mem_req_addr);
        end
        n_chk++;
        if ({bus.icache_ack_data_valid, bus.dcache_ack_data_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ackv: got %b%b want 00",
                bus.icache_ack_data_valid, bus.dcache_ack_data_valid);
        end
        n_chk++;
        if (bus.icache_ack_data !== '0 || bus.dcache_ack_data !== '0) begin
            n_fail++; $display("FAIL reset_ackdata: got nonzero want 0");
        end
        n_chk++;
        if (bus.mem_timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", bus.mem_timeout_err);
        end
    endtask

    task automatic test_single_icache;
        logic [LW-1:0] d;
        d = {8{32'hCAFE_0001}};
        bus.icache_req_addr       = 59'h1234;
        bus.icache_req_addr_valid = 1'b1;
        tick();
        n_chk++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 59'h1234) begin
            n_fail++; $display("FAIL single_req: got v=%b a=%h want v=1 a=1234",
                bus.mem_req_valid, bus.mem_req_addr);
        end
        tick();
        n_chk++;
        if (bus.mem_req_valid !== 1'b0 || bus.arb_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_wait: got v=%b busy=%b want v=0 busy=1",
                bus.mem_req_valid, bus.arb_busy);
        end
        for (int i = 0; i < 4; i++) tick();
        bus.mem_ack_data_valid = 1'b1;
        bus.mem_ack_data       = d;
        tick();
        bus.mem_ack_data_valid = 1'b0;
        bus.mem_ack_data       = '0;
        n_chk++;
        if (bus.icache_ack_data_valid !== 1'b1 || bus.icache_ack_data !== d) begin
            n_fail++; $display("FAIL single_ack: got v=%b d=%h want v=1 d=%h",
                bus.icache_ack_data_valid, bus.icache_ack_data, d);
        end
        n_chk++;
        if (bus.dcache_ack_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_dack: got %b want 0", bus.dcache_ack_data_valid);
        end
        bus.icache_req_addr_valid = 1'b0;
        tick();
        n_chk++;
        if (bus.icache_ack_data_valid !== 1'b0 || bus.arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL single_pulse_end: got v=%b busy=%b want 0 0",
                bus.icache_ack_data_valid, bus.arb_busy);
        end
    endtask

    task automatic test_round_robin;
        logic [LW-1:0] d;
        logic          exp_dc;
        logic [AW-1:0] exp_a;
        idle_inputs();
        do_reset();
        bus.icache_req_addr       = 59'h111;
        bus.dcache_req_addr       = 59'h222;
        bus.icache_req_addr_valid = 1'b1;
        bus.dcache_req_addr_valid = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_dc = k[0];
            exp_a  = exp_dc ? 59'h222 : 59'h111;
            d      = {8{32'hB000_0000 + 32'(k)}};
            n_chk++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== exp_a) begin
                n_fail++; $display("FAIL rr_grant%0d: got v=%b a=%h want v=1 a=%h",
                    k, bus.mem_req_valid, bus.mem_req_addr, exp_a);
            end
            tick();
            bus.mem_ack_data_valid = 1'b1;
            bus.mem_ack_data       = d;
            tick();
            bus.mem_ack_data_valid = 1'b0;
            n_chk++;
            if (bus.icache_ack_data_valid !== ~exp_dc ||
                bus.dcache_ack_data_valid !== exp_dc) begin
                n_fail++; $display("FAIL rr_ack%0d: got i=%b d=%b want i=%b d=%b", k,
                    bus.icache_ack_data_valid, bus.dcache_ack_data_valid, ~exp_dc, exp_dc);
            end
            n_chk++;
            if ((exp_dc ? bus.dcache_ack_data : bus.icache_ack_data) !== d) begin
                n_fail++; $display("FAIL rr_data%0d: wrong line want %h", k, d);
            end
            if (k == 3) begin
                bus.icache_req_addr_valid = 1'b0;
                bus.dcache_req_addr_valid = 1'b0;
            end
            tick();
            n_chk++;
            if (bus.arb_busy !== 1'b0) begin
                n_fail++; $display("FAIL rr_idle%0d: got busy=%b want 0", k, bus.arb_busy);
            end
            tick();
        end
        n_chk++;
        if (bus.mem_req_valid !== 1'b0 || bus.arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL rr_quiet: got v=%b busy=%b want 0 0",
                bus.mem_req_valid, bus.arb_busy);
        end
    endtask

    task automatic test_retry;
        logic [LW-1:0] d;
        d = {8{32'h5EED_0D0D}};
        bus.mem_req_retry         = 1'b1;
        bus.dcache_req_addr       = 59'h0ABC;
        bus.dcache_req_addr_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 59'h0ABC) begin
                n_fail++; $display("FAIL retry_hold%0d: got v=%b a=%h want v=1 a=abc",
                    i, bus.mem_req_valid, bus.mem_req_addr);
            end
            if (i == 3) bus.mem_req_retry = 1'b0;
            tick();
        end
        n_chk++;
        if (bus.mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL retry_accept: got v=%b want 0", bus.mem_req_valid);
        end
        bus.mem_ack_data_valid = 1'b1;
        bus.mem_ack_data       = d;
        tick();
        bus.mem_ack_data_valid = 1'b0;
        n_chk++;
        if (bus.dcache_ack_data_valid !== 1'b1 || bus.dcache_ack_data !== d ||
            bus.icache_ack_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL retry_ack: got d=%b i=%b want d=1 i=0",
                bus.dcache_ack_data_valid, bus.icache_ack_data_valid);
        end
        bus.dcache_req_addr_valid = 1'b0;
        tick();
        tick();
        n_chk++;
        if (bus.mem_req_valid !== 1'b0 || bus.arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL retry_once: got v=%b busy=%b want 0 0",
                bus.mem_req_valid, bus.arb_busy);
        end
    endtask

    task automatic test_spurious;
        logic [LW-1:0] d;
        d = {8{32'h0BAD_F00D}};
        bus.mem_ack_data_valid = 1'b1;
        bus.mem_ack_data       = d;
        tick();
        n_chk++;
        if (bus.icache_ack_data_valid !== 1'b0 || bus.dcache_ack_data_valid !== 1'b0 ||
            bus.arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL spur_idle: got i=%b d=%b busy=%b want 0 0 0",
                bus.icache_ack_data_valid, bus.dcache_ack_data_valid, bus.arb_busy);
        end
        bus.mem_ack_data_valid    = 1'b0;
        bus.mem_req_retry         = 1'b1;
        bus.icache_req_addr       = 59'h77;
        bus.icache_req_addr_valid = 1'b1;
        tick();
        bus.mem_ack_data_valid = 1'b1;
        tick();
        bus.mem_ack_data_valid = 1'b0;
        n_chk++;
        if (bus.mem_req_valid !== 1'b1 || bus.icache_ack_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL spur_req: got v=%b iack=%b want v=1 iack=0",
                bus.mem_req_valid, bus.icache_ack_data_valid);
        end
        bus.mem_req_retry = 1'b0;
        tick();
        bus.mem_ack_data_valid = 1'b1;
        tick();
        bus.mem_ack_data_valid = 1'b0;
        n_chk++;
        if (bus.icache_ack_data_valid !== 1'b1 || bus.icache_ack_data !== d) begin
            n_fail++; $display("FAIL spur_done: got v=%b want v=1 d=%h",
                bus.icache_ack_data_valid, d);
        end
        bus.icache_req_addr_valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        logic [LW-1:0] d;
        d = {8{32'h7173_0008}};
        bus.icache_req_addr       = 59'h3C0;
        bus.icache_req_addr_valid = 1'b1;
        tick();
        tick();
        for (int k = 1; k <= 8; k++) begin
            n_chk++;
            if (bus.mem_timeout_err !== 1'b0) begin
                n_fail++; $display("FAIL to_early%0d: got %b want 0", k, bus.mem_timeout_err);
            end
            tick();
        end
        n_chk++;
        if (bus.mem_timeout_err !== 1'b1 || bus.arb_busy !== 1'b1) begin
            n_fail++; $display("FAIL to_set: got err=%b busy=%b want 1 1",
                bus.mem_timeout_err, bus.arb_busy);
        end
        bus.mem_ack_data_valid = 1'b1;
        bus.mem_ack_data       = d;
        tick();
        bus.mem_ack_data_valid = 1'b0;
        n_chk++;
        if (bus.icache_ack_data_valid !== 1'b1 || bus.icache_ack_data !== d) begin
            n_fail++; $display("FAIL to_late_ack: got v=%b want v=1 d=%h",
                bus.icache_ack_data_valid, d);
        end
        bus.icache_req_addr_valid = 1'b0;
        tick();
        n_chk++;
        if (bus.mem_timeout_err !== 1'b1 || bus.arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL to_sticky: got err=%b busy=%b want 1 0",
                bus.mem_timeout_err, bus.arb_busy);
        end
    endtask

    task automatic test_reset_mid;
        bus.icache_req_addr       = 59'h5A5;
        bus.icache_req_addr_valid = 1'b1;
        tick();
        tick();
        tick();
        bus.icache_req_addr_valid = 1'b0;
        do_reset();
        bus.mem_ack_data_valid = 1'b1;
        bus.mem_ack_data       = {8{32'hFFFF_0000}};
        tick();
        bus.mem_ack_data_valid = 1'b0;
        n_chk++;
        if (bus.icache_ack_data_valid !== 1'b0 || bus.dcache_ack_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pulse: got i=%b d=%b want 0 0",
                bus.icache_ack_data_valid, bus.dcache_ack_data_valid);
        end
        n_chk++;
        if (bus.arb_busy !== 1'b0 || bus.mem_req_valid !== 1'b0 ||
            bus.mem_req_addr !== '0) begin
            n_fail++; $display("FAIL rstmid_state: got busy=%b v=%b a=%h want 0 0 0",
                bus.arb_busy, bus.mem_req_valid, bus.mem_req_addr);
        end
        n_chk++;
        if (bus.mem_timeout_err !== 1'b0 || bus.icache_ack_data !== '0) begin
            n_fail++; $display("FAIL rstmid_outs: got err=%b want 0 and zero data",
                bus.mem_timeout_err);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_icache();
        test_round_robin();
        test_retry();
        test_spurious();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
